shift_right_sequencer: RTL and testbench
========================================

// Module: shift_right_sequencer
// PURPOSE
//  Multi-cycle controller that executes arbitrary symbol right-shifts (0..NUM_SYMBOLS) on a vector
//  using one shift_right datapath instance, which is limited to 0..MAX_STEP symbols per pass.
//  Registers the operand, issues passes of at most MAX_STEP symbols until the requested shift is consumed,
//  and returns the result over a valid/ready handshake. It sits between request producers and shift_right.
// PARAMETERS
//  SYMBOL_WIDTH  5   bits per symbol
//  NUM_SYMBOLS   10  symbols per vector; symbol i = data[SYMBOL_WIDTH*(i+1)-1 : SYMBOL_WIDTH*i]
//  MAX_STEP      4   largest shift per pass; matches the shift_right valid range
//  (localparam) SHIFT_W = $clog2(NUM_SYMBOLS+1) = 4; DATA_W = SYMBOL_WIDTH*NUM_SYMBOLS = 50
// PORTS
//  clk        in   1        clock; all state updates on rising edge
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        request valid
//  in_ready   out  1        request accepted when in_valid && in_ready
//  in_data    in   DATA_W   operand vector
//  in_shift   in   SHIFT_W  total right shift in symbols
//  in_fill    in   SYMBOL_W fill symbol inserted at low indices
//  out_valid  out  1        result valid; held until out_ready
//  out_ready  in   1        result consumed when out_valid && out_ready
//  out_data   out  DATA_W   shifted vector
//  out_err    out  1        request rejected (shift out of range); qualified by out_valid
// BEHAVIOUR
//  - Reset (rst high at edge): state IDLE, out_valid=0, out_err=0, out_data=0, remaining=0. in_ready=1 in IDLE;
//    handshakes are ignored in cycles where rst is high. Reset mid-operation aborts it; the result is discarded.
//  - FSM: IDLE -> SHIFT -> DONE -> IDLE. in_ready = (state==IDLE); one request in flight at a time.
//  - IDLE, accept: data_q<=in_data, fill_q<=in_fill, remaining<=in_shift.
//      in_shift==0         -> DONE, out_data=in_data, out_err=0.
//      in_shift>NUM_SYMBOLS -> DONE, out_data=in_data, out_err=1 (unless SHIFT_SEQ_SATURATE_EN).
//      else                -> SHIFT.
//  - SHIFT, each cycle: step = min(remaining, MAX_STEP); drive shift_right with data_q, step, fill_q;
//    data_q <= result; remaining <= remaining-step; go DONE when remaining-step==0.
//    step is always 1..MAX_STEP, so the instance's out_valid must be 1; if it reads 0, go DONE with out_err=1.
//  - Latency: accept at edge T -> out_valid high after edge T+1+ceil(s/MAX_STEP) (s>0); after T+1 for s==0 or error.
//  - DONE: out_valid=1, out_data/out_err stable while out_ready low. On out_valid&&out_ready -> IDLE,
//    out_valid=0 next cycle; in_ready rises the same cycle (no same-cycle accept while in DONE).
//  - Fill symbol is the one captured at accept; in_fill changes afterwards have no effect.
//  - out_data is a registered output; out_data is don't-care when out_valid=0 but holds its last value.
// CONFIGURATION
//  SHIFT_SEQ_SATURATE_EN defined: in_shift>NUM_SYMBOLS is clamped to NUM_SYMBOLS (result all fill_q,
//    out_err=0, latency as for s=NUM_SYMBOLS). Not defined: such requests return out_err=1, data unchanged.
// TESTING
//  1. in={10{5'h2}}, shift=0, fill=5'h1F -> out_data={10{5'h2}}, out_err=0, out_valid after T+1.
//  2. in symbol i = i, shift=3, fill=5'h1F -> symbols 0..2=1F, 3..9=0..6; one pass; out_valid after T+2.
//  3. in symbol i = i+1, shift=9, fill=5'h3 -> passes 4,4,1; symbols 0..8=3, symbol 9=1; out_valid after T+4.
//  4. shift=10, fill=5'hA -> passes 4,4,2; all symbols 5'hA, out_err=0, out_valid after T+4.
//  5. shift=12, in={10{5'h5}} -> no macro: out_err=1, out_data={10{5'h5}}, out_valid after T+1;
//     SHIFT_SEQ_SATURATE_EN: all-fill result, out_err=0, out_valid after T+4.
//  6. out_ready low 5 cycles in DONE -> out_data/out_err stable, in_ready=0; rst pulsed mid-SHIFT
//     (shift=9) -> out_valid=0, in_ready=1 after the reset edge, no stale result emitted.

Source files
------------

// File: rtl/shift_right_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | shift_right_sequencer: multi-pass symbol right-shift over a valid/ready   |
// | handshake. Optional macro: SHIFT_SEQ_SATURATE_EN. Revision 1.0            |
// +--------------------------------------------------------------------------+

module shift_right #(
  parameter int SYMBOL_WIDTH = 5,
  parameter int NUM_SYMBOLS  = 10,
  parameter int MAX_STEP     = 4,
  parameter int SHIFT_W      = 4,
  parameter int DATA_W       = SYMBOL_WIDTH * NUM_SYMBOLS
) (
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SHIFT_W-1:0]      in_shift,
  input  logic [SYMBOL_WIDTH-1:0] in_fill,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_valid
);

  always_comb begin
    out_valid = (in_shift <= SHIFT_W'(MAX_STEP));
    out_data  = in_data;
    if (out_valid) begin
      // Symbols move toward higher indices; vacated low indices take the fill.
      for (int i = 0; i < NUM_SYMBOLS; i++) begin
        if (i < int'(in_shift))
          out_data[i*SYMBOL_WIDTH +: SYMBOL_WIDTH] = in_fill;
        else
          out_data[i*SYMBOL_WIDTH +: SYMBOL_WIDTH] =
            in_data[(i - int'(in_shift))*SYMBOL_WIDTH +: SYMBOL_WIDTH];
      end
    end
  end

endmodule

module shift_right_sequencer #(
  parameter int SYMBOL_WIDTH = 5,
  parameter int NUM_SYMBOLS  = 10,
  parameter int MAX_STEP     = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [SYMBOL_WIDTH*NUM_SYMBOLS-1:0]    in_data,
  input  logic [$clog2(NUM_SYMBOLS+1)-1:0]       in_shift,
  input  logic [SYMBOL_WIDTH-1:0]                in_fill,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [SYMBOL_WIDTH*NUM_SYMBOLS-1:0]    out_data,
  output logic                                   out_err
);

  localparam int SHIFT_W = $clog2(NUM_SYMBOLS + 1);
  localparam int DATA_W  = SYMBOL_WIDTH * NUM_SYMBOLS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic [SYMBOL_WIDTH-1:0] fill_q, fill_d;
  logic [SHIFT_W-1:0]      remaining_q, remaining_d;
  logic                    err_q, err_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_err_q, out_err_d;
  logic [DATA_W-1:0]       out_data_q, out_data_d;

  logic [SHIFT_W-1:0]      step;
  logic [DATA_W-1:0]       sr_data;
  logic                    sr_valid;

  assign step = (remaining_q > SHIFT_W'(MAX_STEP)) ? SHIFT_W'(MAX_STEP) : remaining_q;

  shift_right #(
    .SYMBOL_WIDTH (SYMBOL_WIDTH),
    .NUM_SYMBOLS  (NUM_SYMBOLS),
    .MAX_STEP     (MAX_STEP),
    .SHIFT_W      (SHIFT_W),
    .DATA_W       (DATA_W)
  ) u_shift_right (
    .in_data   (data_q),
    .in_shift  (step),
    .in_fill   (fill_q),
    .out_data  (sr_data),
    .out_valid (sr_valid)
  );

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    fill_d      = fill_q;
    remaining_d = remaining_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_err_d   = out_err_q;
    out_data_d  = out_data_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d      = in_data;
          fill_d      = in_fill;
          remaining_d = in_shift;
          err_d       = 1'b0;
          if (in_shift == '0) begin
            state_d = ST_DONE;
          end else if (in_shift > SHIFT_W'(NUM_SYMBOLS)) begin
`ifdef SHIFT_SEQ_SATURATE_EN
            remaining_d = SHIFT_W'(NUM_SYMBOLS);
            state_d     = ST_SHIFT;
`else
            err_d   = 1'b1;
            state_d = ST_DONE;
`endif
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end

      ST_SHIFT: begin
        if (!sr_valid) begin
          err_d       = 1'b1;
          remaining_d = '0;
          state_d     = ST_DONE;
        end else begin
          data_d      = sr_data;
          remaining_d = remaining_q - step;
          if (remaining_q == step)
            state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        // First DONE cycle loads the result registers; handshake from then on.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = data_q;
          out_err_d   = err_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      fill_q      <= '0;
      remaining_q <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      fill_q      <= fill_d;
      remaining_q <= remaining_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_err   = out_err_q;
  assign out_data  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_right_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_shift_right_sequencer: vector table + random requests vs. symbol model |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_shift_right_sequencer;

  localparam int SW = 5;
  localparam int N  = 10;
  localparam int MS = 4;
  localparam int KW = 4;
  localparam int DW = SW * N;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [KW-1:0] in_shift;
  logic [SW-1:0] in_fill;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_err;

  int checks = 0;
  int errors = 0;

  shift_right_sequencer #(
    .SYMBOL_WIDTH (SW),
    .NUM_SYMBOLS  (N),
    .MAX_STEP     (MS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shift  (in_shift),
    .in_fill   (in_fill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] shift;
    logic [SW-1:0] fill;
    logic [DW-1:0] exp_data;
    logic          exp_err;
    int            exp_lat;
    int            hold;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: symbol array view, rules stated per output symbol.
  task automatic model(input logic [DW-1:0] d, input int s, input logic [SW-1:0] f,
                       output logic [DW-1:0] r, output logic e, output int lat);
    logic [SW-1:0] sym [N];
    int eff;
    for (int i = 0; i < N; i++) sym[i] = d[i*SW +: SW];
    e   = 1'b0;
    eff = s;
    if (s > N) begin
`ifdef SHIFT_SEQ_SATURATE_EN
      eff = N;
`else
      e   = 1'b1;
      eff = 0;
`endif
    end
    r = '0;
    for (int i = 0; i < N; i++)
      r[i*SW +: SW] = (i < eff) ? f : sym[i - eff];
    lat = (eff == 0) ? 1 : 1 + (eff + MS - 1) / MS;
  endtask

  task automatic run_req(input logic [DW-1:0] d, input logic [KW-1:0] s, input logic [SW-1:0] f,
                         input logic [DW-1:0] ed, input logic ee, input int el, input int hold,
                         input string tag);
    int k;
    logic [63:0] rnd;
    k = 0;
    while (!in_ready && k < 20) begin
      @(posedge clk); #1; k++;
    end
    chk({tag, " in_ready idle"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_data = d; in_shift = s; in_fill = f;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rnd = {$urandom, $urandom};
    in_data = rnd[DW-1:0];
    in_fill = SW'($urandom);
    chk({tag, " busy in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, " early out_valid"}, 64'(out_valid), 64'd0);
    k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (!out_valid && k < 20);
    chk({tag, " latency"}, 64'(k), 64'(el));
    if (!out_valid) return;
    chk({tag, " data"}, 64'(out_data), 64'(ed));
    chk({tag, " err"}, 64'(out_err), 64'(ee));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, " hold valid/ready"}, {62'd0, out_valid, in_ready}, 64'd2);
      chk({tag, " hold data/err"}, {13'd0, out_err, out_data}, {13'd0, ee, ed});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " post-handshake valid/ready"}, {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  vec_t vecs [8];

  initial begin
    logic [DW-1:0] ramp0, ramp1, rd, ed;
    logic [63:0]   rnd;
    logic          ee;
    int            el, s;
    logic [SW-1:0] rf;

    ramp0 = {5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0};
    ramp1 = {5'd10, 5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};

    vecs[0] = '{ {10{5'h2}}, 4'd0, 5'h1F, {10{5'h2}}, 1'b0, 1, 0 };
    vecs[1] = '{ ramp0, 4'd3, 5'h1F,
                 {5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0, 5'h1F, 5'h1F, 5'h1F}, 1'b0, 2, 0 };
    vecs[2] = '{ ramp1, 4'd9, 5'h3, {5'd1, {9{5'h3}}}, 1'b0, 4, 0 };
    vecs[3] = '{ ramp0, 4'd10, 5'hA, {10{5'hA}}, 1'b0, 4, 0 };
`ifdef SHIFT_SEQ_SATURATE_EN
    vecs[4] = '{ {10{5'h5}}, 4'd12, 5'h7, {10{5'h7}}, 1'b0, 4, 0 };
    vecs[5] = '{ ramp0, 4'd15, 5'h11, {10{5'h11}}, 1'b0, 4, 0 };
`else
    vecs[4] = '{ {10{5'h5}}, 4'd12, 5'h7, {10{5'h5}}, 1'b1, 1, 0 };
    vecs[5] = '{ ramp0, 4'd15, 5'h11, ramp0, 1'b1, 1, 0 };
`endif
    vecs[6] = '{ ramp0, 4'd4, 5'h0,
                 {5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0, 5'h0, 5'h0, 5'h0, 5'h0}, 1'b0, 2, 0 };
    vecs[7] = '{ ramp1, 4'd5, 5'h1C,
                 {5'd5, 5'd4, 5'd3, 5'd2, 5'd1, {5{5'h1C}}}, 1'b0, 3, 5 };

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shift = '0; in_fill = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset out_valid/in_ready", {62'd0, out_valid, in_ready}, 64'd1);
    chk("reset out_err", 64'(out_err), 64'd0);
    chk("reset out_data", 64'(out_data), 64'd0);

    for (int v = 0; v < 8; v++)
      run_req(vecs[v].data, vecs[v].shift, vecs[v].fill, vecs[v].exp_data,
              vecs[v].exp_err, vecs[v].exp_lat, vecs[v].hold, $sformatf("vec%0d", v));

    // Reset one pass into a 9-symbol shift: nothing may come out afterwards.
    in_valid = 1'b1; in_data = ramp1; in_shift = 4'd9; in_fill = 5'h3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("midshift busy", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort valid/ready", {62'd0, out_valid, in_ready}, 64'd1);
    chk("abort out_data", 64'(out_data), 64'd0);
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      chk("abort no stale result", 64'(seen), 64'd0);
    end

    for (int r = 0; r < 40; r++) begin
      rnd = {$urandom, $urandom};
      rd  = rnd[DW-1:0];
      s   = $urandom_range(0, 15);
      rf  = SW'($urandom);
      model(rd, s, rf, ed, ee, el);
      run_req(rd, KW'(s), rf, ed, ee, el, $urandom_range(0, 2), $sformatf("rnd%0d s=%0d", r, s));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
